// File: rtl/motor_pkg.sv
// Shared command codes, channel state type and command decode for the dual H-bridge driver.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
//
// Also used for pin encoding: a channel's IN pin pair equals the command code it is running.
package motor_pkg;

    localparam logic [1:0] CMD_FWD   = 2'b10;
    localparam logic [1:0] CMD_REV   = 2'b01;
    localparam logic [1:0] CMD_BRAKE = 2'b11;
    localparam logic [1:0] CMD_COAST = 2'b00;

    typedef enum logic [2:0] {
        BRAKE,
        COAST,
        RUN_FWD,
        RUN_REV,
        DEAD
    } ch_state_t;

    // State a channel settles in for a given command, ignoring dead-time.
    function automatic ch_state_t cmd_to_state(input logic [1:0] cmd);
        ch_state_t s;
        case (cmd)
            CMD_FWD:   s = RUN_FWD;
            CMD_REV:   s = RUN_REV;
            CMD_COAST: s = COAST;
            default:   s = BRAKE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/motor_bridge_channel.sv
// One H-bridge channel: command FSM, reversal dead-time, soft-start duty ramp, registered IN/EN pins.
// Latency: 1 clk from cmd to pins (cmd is already registered by the top level).
// Backpressure: none; every command is accepted each cycle.
//
// Ports: cmd (registered 2-bit command), pwm_cnt (shared counter value for this edge),
//        ramp_tick (only with MOTOR_SOFTSTART_EN), bridge_in (IN pin pair), bridge_pwm (EN pin),
//        busy (DEAD, or ramping below full duty).
// Build option: MOTOR_SOFTSTART_EN enables the duty ramp; otherwise RUN starts at DUTY_MAX.
module motor_bridge_channel
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD  = 1000,
    parameter int DUTY_MAX    = 800,
    parameter int RAMP_STEP   = 20,
    parameter int DEAD_CYCLES = 200,
    localparam int DW = $clog2(PWM_PERIOD + 1),
    localparam int CW = $clog2(PWM_PERIOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    cmd,
    input  logic [CW-1:0] pwm_cnt,
`ifdef MOTOR_SOFTSTART_EN
    input  logic          ramp_tick,
`endif
    output logic [1:0]    bridge_in,
    output logic          bridge_pwm,
    output logic          busy
);

    localparam int              DCW       = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0]   DUTY_TOP  = DW'(DUTY_MAX);
    localparam logic [DCW-1:0]  DEAD_LOAD = DCW'(DEAD_CYCLES);
`ifdef MOTOR_SOFTSTART_EN
    localparam logic [DW:0]     STEP_X     = (DW + 1)'(RAMP_STEP);
    localparam logic [DW-1:0]   DUTY_ENTRY = '0;
`else
    localparam int              unused_ramp_step = RAMP_STEP;
    localparam logic [DW-1:0]   DUTY_ENTRY = DUTY_TOP;
`endif

    ch_state_t      state, state_n;
    logic [DCW-1:0] dead_cnt, dead_n;
    logic [DW-1:0]  duty, duty_n;
    logic [1:0]     in_n;
    logic           pwm_n;
    logic           busy_n;
    logic           stop_cmd;

    assign stop_cmd = (cmd == CMD_BRAKE) || (cmd == CMD_COAST);

`ifdef MOTOR_SOFTSTART_EN
    // One bit wider than duty so the saturation compare cannot wrap.
    logic [DW:0] duty_sum;
    assign duty_sum = {1'b0, duty} + STEP_X;
`endif

    always_comb begin
        state_n = state;
        dead_n  = dead_cnt;
        duty_n  = duty;
        case (state)
            BRAKE, COAST: begin
                state_n = cmd_to_state(cmd);
                duty_n  = stop_cmd ? '0 : DUTY_ENTRY;
            end
            RUN_FWD, RUN_REV: begin
                if (stop_cmd) begin
                    state_n = cmd_to_state(cmd);
                    duty_n  = '0;
                end else if (cmd_to_state(cmd) != state) begin
                    state_n = DEAD;
                    dead_n  = DEAD_LOAD;
                    duty_n  = '0;
                end
`ifdef MOTOR_SOFTSTART_EN
                else if (ramp_tick) begin
                    duty_n = (duty_sum > {1'b0, DUTY_TOP}) ? DUTY_TOP : duty_sum[DW-1:0];
                end
`endif
            end
            DEAD: begin
                // Target tracks cmd without restarting the count; stop commands bail out at once.
                if (stop_cmd) begin
                    state_n = cmd_to_state(cmd);
                    dead_n  = '0;
                end else if (dead_cnt == DCW'(1)) begin
                    state_n = cmd_to_state(cmd);
                    dead_n  = '0;
                    duty_n  = DUTY_ENTRY;
                end else begin
                    dead_n = dead_cnt - DCW'(1);
                end
            end
            default: begin
                state_n = BRAKE;
                dead_n  = '0;
                duty_n  = '0;
            end
        endcase

        // Pins are registered from the next state so they line up with it.
        in_n  = CMD_COAST;
        pwm_n = 1'b0;
        case (state_n)
            BRAKE: begin
                in_n  = CMD_BRAKE;
                pwm_n = 1'b1;
            end
            RUN_FWD: begin
                in_n  = CMD_FWD;
                pwm_n = DW'(pwm_cnt) < duty_n;
            end
            RUN_REV: begin
                in_n  = CMD_REV;
                pwm_n = DW'(pwm_cnt) < duty_n;
            end
            default: ;
        endcase

        busy_n = (state_n == DEAD);
`ifdef MOTOR_SOFTSTART_EN
        if ((state_n == RUN_FWD || state_n == RUN_REV) && duty_n < DUTY_TOP) begin
            busy_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BRAKE;
            dead_cnt   <= '0;
            duty       <= '0;
            bridge_in  <= CMD_BRAKE;
            bridge_pwm <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            dead_cnt   <= dead_n;
            duty       <= duty_n;
            bridge_in  <= in_n;
            bridge_pwm <= pwm_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: rtl/motor_bridge_drive.sv
// Dual H-bridge driver: registers the 4-bit steering command and runs two motor channels off shared PWM/ramp timers.
// Latency: 2 clk from en to bridge pins (command register + channel output register).
// Backpressure: none; en is sampled every cycle.
//
// Ports: en[3:2] left / en[1:0] right command; bridge_in[3:2] left IN1/IN2, [1:0] right IN3/IN4;
//        bridge_pwm[1] ENA left, [0] ENB right; busy[1] left, [0] right.
// Build option: MOTOR_SOFTSTART_EN adds the shared ramp divider and per-channel duty ramp.
module motor_bridge_drive
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD  = 1000,
    parameter int DUTY_MAX    = 800,
    parameter int RAMP_STEP   = 20,
    parameter int RAMP_DIV    = 5000,
    parameter int DEAD_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] en,
    output logic [3:0] bridge_in,
    output logic [1:0] bridge_pwm,
    output logic [1:0] busy
);

    localparam int CW = $clog2(PWM_PERIOD);

    logic [3:0]    cmd_q;
    logic [CW-1:0] pwm_cnt, pwm_cnt_nxt;

    // Reset to brake so releasing reset with a brake command causes no glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= {CMD_BRAKE, CMD_BRAKE};
        end else begin
            cmd_q <= en;
        end
    end

    // Channels compare against the post-edge count so pin and counter agree.
    assign pwm_cnt_nxt = (pwm_cnt == CW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt_nxt;
        end
    end

`ifdef MOTOR_SOFTSTART_EN
    localparam int RW = $clog2(RAMP_DIV);

    logic [RW-1:0] ramp_div;
    logic          ramp_tick;

    assign ramp_tick = (ramp_div == RW'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_div <= '0;
        end else begin
            ramp_div <= ramp_tick ? '0 : ramp_div + RW'(1);
        end
    end
`else
    localparam int unused_ramp_div = RAMP_DIV;
`endif

    motor_bridge_channel #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_MAX   (DUTY_MAX),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_left (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_q[3:2]),
        .pwm_cnt   (pwm_cnt_nxt),
`ifdef MOTOR_SOFTSTART_EN
        .ramp_tick (ramp_tick),
`endif
        .bridge_in (bridge_in[3:2]),
        .bridge_pwm(bridge_pwm[1]),
        .busy      (busy[1])
    );

    motor_bridge_channel #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_MAX   (DUTY_MAX),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_right (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_q[1:0]),
        .pwm_cnt   (pwm_cnt_nxt),
`ifdef MOTOR_SOFTSTART_EN
        .ramp_tick (ramp_tick),
`endif
        .bridge_in (bridge_in[1:0]),
        .bridge_pwm(bridge_pwm[0]),
        .busy      (busy[0])
    );

endmodule

// File: tb/tb_motor_bridge_drive.sv
// Testbench for motor_bridge_drive: vector table, directed corner sequences and random commands
// checked every cycle against a behavioural model of the two motor channels.
module tb_motor_bridge_drive;

    localparam int P    = 100;
    localparam int DMAX = 80;
    localparam int STEP = 10;
    localparam int DIV  = 50;
    localparam int DC   = 20;
`ifdef MOTOR_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] en;
    logic [3:0] bridge_in;
    logic [1:0] bridge_pwm;
    logic [1:0] busy;

    motor_bridge_drive #(
        .PWM_PERIOD (P),
        .DUTY_MAX   (DMAX),
        .RAMP_STEP  (STEP),
        .RAMP_DIV   (DIV),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bridge_in (bridge_in),
        .bridge_pwm(bridge_pwm),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model. Channel 0 = right (en[1:0]), 1 = left (en[3:2]).
    // dir: +1 forward, -1 reverse, 0 stopped (brake flag tells brake vs coast).
    // dead_left > 0 means the channel is in its reversal gap.
    int         m_dir       [2];
    bit         m_brake     [2];
    int         m_dead_left [2];
    int         m_duty      [2];
    logic [3:0] m_cmd;
    int         m_edges;

    typedef struct {
        logic [3:0] en;
        logic [3:0] exp_in;
        logic [1:0] pwm_mask;
        logic [1:0] exp_pwm;
    } vec_t;

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_dir[ch]       = 0;
            m_brake[ch]     = 1'b1;
            m_dead_left[ch] = 0;
            m_duty[ch]      = 0;
        end
        m_cmd   = 4'b1111;
        m_edges = 0;
    endtask

    task automatic model_advance();
        bit         tick;
        logic [1:0] c;
        int         want;
        m_edges++;
        tick = SOFT && (m_edges % DIV == 0);
        for (int ch = 0; ch < 2; ch++) begin
            c    = m_cmd[ch*2 +: 2];
            want = (c == 2'b10) ? 1 : (c == 2'b01) ? -1 : 0;
            if (m_dead_left[ch] > 0) begin
                if (want == 0) begin
                    m_dead_left[ch] = 0;
                    m_dir[ch]       = 0;
                    m_brake[ch]     = (c == 2'b11);
                end else if (m_dead_left[ch] == 1) begin
                    m_dead_left[ch] = 0;
                    m_dir[ch]       = want;
                    m_duty[ch]      = SOFT ? 0 : DMAX;
                end else begin
                    m_dead_left[ch]--;
                end
            end else if (m_dir[ch] != 0) begin
                if (want == 0) begin
                    m_dir[ch]   = 0;
                    m_brake[ch] = (c == 2'b11);
                    m_duty[ch]  = 0;
                end else if (want == -m_dir[ch]) begin
                    m_dir[ch]       = 0;
                    m_dead_left[ch] = DC;
                    m_duty[ch]      = 0;
                end else if (tick) begin
                    m_duty[ch] = (m_duty[ch] + STEP > DMAX) ? DMAX : m_duty[ch] + STEP;
                end
            end else begin
                m_dir[ch]   = want;
                m_brake[ch] = (c == 2'b11);
                m_duty[ch]  = (want != 0 && !SOFT) ? DMAX : 0;
            end
        end
        m_cmd = en;
    endtask

    task automatic check_model();
        logic [3:0] ei;
        logic [1:0] ep;
        logic [1:0] eb;
        ei = '0;
        ep = '0;
        eb = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (m_dead_left[ch] > 0) begin
                ei[ch*2 +: 2] = 2'b00;
                ep[ch]        = 1'b0;
            end else if (m_dir[ch] != 0) begin
                ei[ch*2 +: 2] = (m_dir[ch] > 0) ? 2'b10 : 2'b01;
                ep[ch]        = ((m_edges % P) < m_duty[ch]);
            end else begin
                ei[ch*2 +: 2] = m_brake[ch] ? 2'b11 : 2'b00;
                ep[ch]        = m_brake[ch];
            end
            eb[ch] = (m_dead_left[ch] > 0) || (SOFT && m_dir[ch] != 0 && m_duty[ch] < DMAX);
        end
        n_checks++;
        if ({bridge_in, bridge_pwm, busy} !== {ei, ep, eb}) begin
            n_fail++;
            $display("FAIL model t=%0t got in=%b pwm=%b busy=%b want in=%b pwm=%b busy=%b",
                     $time, bridge_in, bridge_pwm, busy, ei, ep, eb);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_advance();
        @(negedge clk);
        check_model();
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic [1:0] pick_cmd();
        logic [1:0] c;
        case ($urandom_range(0, 5))
            0, 1:    c = 2'b10;
            2, 3:    c = 2'b01;
            4:       c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    initial begin
        vec_t tbl [8];
        int   cnt_l;
        int   cnt_r;
        int   n;
        int   k;
        bit   ok;

        tbl[0] = '{4'b1111, 4'b1111, 2'b11, 2'b11};
        tbl[1] = '{4'b0000, 4'b0000, 2'b11, 2'b00};
        tbl[2] = '{4'b1100, 4'b1100, 2'b11, 2'b10};
        tbl[3] = '{4'b0011, 4'b0011, 2'b11, 2'b01};
        tbl[4] = '{4'b1000, 4'b1000, 2'b01, 2'b00};
        tbl[5] = '{4'b0100, 4'b0000, 2'b11, 2'b00};
        tbl[6] = '{4'b0111, 4'b0011, 2'b11, 2'b01};
        tbl[7] = '{4'b1111, 4'b1111, 2'b11, 2'b11};

        // Reset hold and release with brake command.
        rst_n = 1'b0;
        en    = 4'b1111;
        model_reset();
        repeat (3) cyc();
        chk("reset_hold", int'({bridge_in, bridge_pwm, busy}), int'(8'b1111_1100));
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("reset_release", int'({bridge_in, bridge_pwm, busy}), int'(8'b1111_1100));

        // Command table, pins sampled two cycles after each change.
        for (int i = 0; i < 8; i++) begin
            en = tbl[i].en;
            cyc();
            cyc();
            chk($sformatf("vec%0d_in", i), int'(bridge_in), int'(tbl[i].exp_in));
            chk($sformatf("vec%0d_pwm", i), int'(bridge_pwm & tbl[i].pwm_mask), int'(tbl[i].exp_pwm));
        end

        // Both forward: ramp to full duty, then 80 of 100 cycles high.
        en = 4'b1010;
        cyc();
        cyc();
        chk("fwd_pins", int'(bridge_in), int'(4'b1010));
        chk("fwd_busy", int'(busy), SOFT ? 3 : 0);
        n = 0;
        while (busy != 2'b00 && n < 600) begin
            cyc();
            n++;
        end
        chk("ramp_done_busy", int'(busy), 0);
        cnt_l = 0;
        cnt_r = 0;
        for (int i = 0; i < P; i++) begin
            cyc();
            cnt_l += int'(bridge_pwm[1]);
            cnt_r += int'(bridge_pwm[0]);
        end
        chk("duty_left", cnt_l, DMAX);
        chk("duty_right", cnt_r, DMAX);

        // Left reversal: dead gap length, right undisturbed.
        en = 4'b0110;
        cyc();
        cyc();
        n  = 0;
        ok = 1'b1;
        while (bridge_in[3:2] == 2'b00 && n < 100) begin
            n++;
            if (bridge_in[1:0] != 2'b10 || bridge_pwm[1] != 1'b0) ok = 1'b0;
            cyc();
        end
        chk("dead_len", n, DC);
        chk("dead_right_undisturbed", int'(ok), 1);
        chk("rev_pins", int'(bridge_in), int'(4'b0110));

        // Reversal aborted by brake during dead time.
        en = 4'b1010;
        cyc();
        cyc();
        chk("dead_enter", int'(bridge_in[3:2]), 0);
        repeat (4) cyc();
        en = 4'b1110;
        cyc();
        cyc();
        chk("dead_abort_brake", int'({bridge_in[3:2], bridge_pwm[1]}), int'(3'b111));

        // Asynchronous reset mid-period while running.
        en = 4'b1010;
        n  = 0;
        while (m_duty[1] != (SOFT ? 40 : DMAX) && n < 1000) begin
            cyc();
            n++;
        end
        chk("left_duty_reached", m_duty[1], SOFT ? 40 : DMAX);
        @(posedge clk);
        model_advance();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset", int'({bridge_in, bridge_pwm, busy}), int'(8'b1111_1100));
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("restart_pins", int'(bridge_in), int'(4'b1010));
        chk("restart_busy", int'(busy), SOFT ? 3 : 0);
        chk("restart_pwm", int'(bridge_pwm), SOFT ? 0 : 3);

`ifndef MOTOR_SOFTSTART_EN
        // Without soft-start the left motor runs full duty from its first period.
        en = 4'b1111;
        repeat (3) cyc();
        en = 4'b1011;
        cyc();
        cyc();
        cnt_l = 0;
        ok    = 1'b1;
        for (int i = 0; i < P; i++) begin
            cnt_l += int'(bridge_pwm[1]);
            if (bridge_in[1:0] != 2'b11 || bridge_pwm[0] != 1'b1) ok = 1'b0;
            cyc();
        end
        chk("nosoft_left_duty", cnt_l, DMAX);
        chk("nosoft_right_brake", int'(ok), 1);
`endif

        // Random command segments, some long enough to finish a ramp.
        for (int s = 0; s < 200; s++) begin
            en = {pick_cmd(), pick_cmd()};
            k  = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 450) : $urandom_range(1, 40);
            repeat (k) cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_bridge_drive.md
Name: motor_bridge_drive

Overview:
- Consumes the 4-bit motor enable code from the line-follower steering logic and drives a dual H-bridge (L298N-style: INx direction pins plus ENx PWM pins).
- Two identical channels, each with:
  - command decode
  - forward/reverse dead-time
  - soft-start duty ramp
  - PWM generation
- Sits between the steering decision logic and the chip's motor pins.

Parameters:
- PWM_PERIOD, 1000: PWM period in clk cycles.
- DUTY_MAX, 800: run duty in counts; 0..PWM_PERIOD; PWM_PERIOD means always on.
- RAMP_STEP, 20: duty increment per ramp tick.
- RAMP_DIV, 5000: clk cycles per ramp tick.
- DEAD_CYCLES, 200: all-off interval on a forward<->reverse reversal; must be >=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  4  command; en[3:2] = left motor, en[1:0] = right motor
- bridge_in  out  4  H-bridge direction pins; [3:2] = left IN1/IN2, [1:0] = right IN3/IN4
- bridge_pwm  out  2  H-bridge enable pins; [1] = ENA left, [0] = ENB right
- busy  out  2  per channel: 1 while in DEAD or while ramping (duty < DUTY_MAX in RUN)

Behaviour:
- Reset: clock clk; reset rst_n, asynchronous, active-low. All of the following take effect immediately on reset assertion:
  - bridge_in = 4'b1111 and bridge_pwm = 2'b11 (both motors braking)
  - busy = 0, PWM counter = 0, ramp divider = 0, both channels in BRAKE with duty = 0
- Per-channel command code {a,b}:
  - 10 = forward, 01 = reverse, 11 = brake, 00 = coast
  - Example: en=1010 drives both forward; en=1110 gives left brake / right forward.
- en is registered once (cmd_q). State and outputs are registered, so a pin change appears 2 clk cycles after en changes.
- Shared PWM counter: runs 0..PWM_PERIOD-1 and wraps to 0.
- Shared ramp divider: runs 0..RAMP_DIV-1; emits a tick when it wraps.
- Per-channel states and outputs:
  - BRAKE: in = 11, pwm = 1, duty = 0.
  - COAST: in = 00, pwm = 0, duty = 0.
  - RUN_FWD / RUN_REV: in = 10 / 01; pwm = 1 iff PWM counter < duty. Duty = 0 gives constant 0.
  - DEAD: in = 00, pwm = 0, duty = 0.
- Transitions, evaluated each cycle on cmd_q:
  - BRAKE/COAST -> any command: go directly to the commanded state; duty restarts at 0.
  - RUN_x -> brake/coast: go immediately; duty cleared.
  - RUN_FWD <-> RUN_REV: enter DEAD and load the dead counter with DEAD_CYCLES. On expiry, go to the state for the latest cmd_q, with duty = 0.
  - cmd_q changes during DEAD: target follows cmd_q; the counter is NOT restarted. Exception: if cmd_q becomes brake or coast, leave DEAD immediately.
  - Unchanged command: no transition; the ramp continues.
- Ramp, in RUN only:
  - On each ramp tick, duty = min(duty + RAMP_STEP, DUTY_MAX), saturating.
  - The addition is computed one bit wider than the duty to avoid overflow.
- Duty width: clog2(PWM_PERIOD+1). PWM counter width: clog2(PWM_PERIOD).
- Reset asserted mid-operation (any state): return to the reset values; no dead-time is enforced.

Optional Feature:
- Macro MOTOR_SOFTSTART_EN.
- Defined: duty ramps as described above; busy is set during the ramp.
- Undefined: entering RUN loads duty = DUTY_MAX immediately; the ramp divider is not instantiated; busy reflects DEAD only.

Decomposition:
- Shared package motor_pkg contains:
  - command code constants CMD_FWD = 2'b10, CMD_REV = 2'b01, CMD_BRAKE = 2'b11, CMD_COAST = 2'b00
  - the channel state enum {BRAKE, COAST, RUN_FWD, RUN_REV, DEAD}
- Sub-module motor_bridge_channel, instantiated twice:
  - owns the state machine, dead counter, duty register and output registers
  - receives the shared PWM count and ramp tick from the top level

Test Plan (PWM_PERIOD=100, DUTY_MAX=80, RAMP_STEP=10, RAMP_DIV=50, DEAD_CYCLES=20):
- Reset hold, then release with en=1111 -> bridge_in=1111, bridge_pwm=11, busy=00 throughout.
- en=1010 at cycle t -> bridge_in=1010 at t+2. Duty rises by 10 every 50 cycles and reaches 80 after 8 ticks; busy drops at that point. Then pwm high for exactly 80 of every 100 cycles.
- Left reversal: en 1010 -> 0110 -> left in=00 and pwm=0 for 20 cycles, then left in=01 with duty starting at 0. Right channel is undisturbed.
- During the left DEAD window, en -> 1110 at dead cycle 5 -> left goes immediately to BRAKE (in=11, pwm=1).
- Running with duty 40, assert rst_n=0 asynchronously mid-period -> outputs become 1111/11 the same instant. After release with en=1010, the ramp restarts from 0.
- Build without MOTOR_SOFTSTART_EN, en=1011 -> right channel brakes; left channel runs at 80/100 duty from its first PWM period.
